// File: rtl/trigger_frame_packer.sv
// Condenses per-phase trigger requests into one tagged frame per bunch crossing
// and queues the frames in a first-word-fall-through FIFO for the TCM link.
module trigger_frame_packer #(
    parameter int TT_W      = 7,
    parameter int TA_W      = 12,
    parameter int DEPTH     = 16,
    parameter int ORBIT_LEN = 3564,
    parameter int FRAME_W   = 15 + TT_W + TA_W
) (
    input  logic                     clk320,
    input  logic                     rst_n,
    input  logic [2:0]               mt_cou,
    input  logic                     tcm_req,
    input  logic [TT_W-1:0]          tt,
    input  logic [TA_W-1:0]          ta,
    input  logic                     orbit,
    output logic [FRAME_W-1:0]       out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic ACC_IDLE = 1'b0;
    localparam logic ACC_HIT  = 1'b1;

    logic                acc_q, acc_d;
    logic [2:0]          req_cnt_q, req_cnt_d;
    logic [TT_W-1:0]     tt_cap_q, tt_cap_d;
    logic [TA_W-1:0]     ta_max_q, ta_max_d;
    logic [11:0]         bc_id_q, bc_id_d;
    logic                orbit_pend_q, orbit_pend_d;

    logic [FRAME_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [FRAME_W-1:0]  out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         drop_q, drop_d;

    logic                hit_f;
    logic [2:0]          cnt_f;
    logic [TT_W-1:0]     tt_f;
    logic [TA_W-1:0]     ta_f;
    logic                boundary, push, pop, full, push_ok, drop, mem_empty, wr_en;
    logic [FRAME_W-1:0]  frame;

    // Accumulator as it stands once this edge's request is folded in; the
    // boundary frame is built from this so a phase-7 request is not lost.
    always_comb begin
        hit_f = acc_q;
        cnt_f = req_cnt_q;
        tt_f  = tt_cap_q;
        ta_f  = ta_max_q;
        if (tcm_req) begin
            if (acc_q == ACC_IDLE) begin
                hit_f = ACC_HIT;
                cnt_f = 3'd1;
                tt_f  = tt;
                ta_f  = ta;
            end else begin
                if (req_cnt_q != 3'd7) cnt_f = req_cnt_q + 3'd1;
                if (ta > ta_max_q)     ta_f  = ta;
            end
        end
    end

    assign boundary = (mt_cou == 3'd7);
    assign push     = boundary && (hit_f == ACC_HIT);
    assign frame    = {bc_id_q, cnt_f, tt_f, ta_f};

    always_comb begin
        acc_d        = boundary ? ACC_IDLE : hit_f;
        req_cnt_d    = boundary ? 3'd0 : cnt_f;
        tt_cap_d     = tt_f;
        ta_max_d     = ta_f;
        bc_id_d      = bc_id_q;
        orbit_pend_d = orbit_pend_q;
        if (boundary) begin
            if (orbit_pend_q || orbit) begin
                bc_id_d      = '0;
                orbit_pend_d = 1'b0;
            end else begin
                bc_id_d = (bc_id_q == 12'(ORBIT_LEN - 1)) ? '0 : bc_id_q + 12'd1;
            end
        end else if (orbit) begin
            orbit_pend_d = 1'b1;
        end
    end

    assign pop       = out_valid_q && out_ready;
    assign full      = (level_q == LW'(DEPTH));
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign mem_empty = (rd_q == wr_q);

    // The output register holds the head frame; mem_q holds the rest. A push
    // into an empty queue bypasses mem_q straight into the output register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_d        = rd_q;
        wr_en       = 1'b0;
        if (!out_valid_q || pop) begin
            if (!mem_empty) begin
                out_data_d  = mem_q[rd_q];
                out_valid_d = 1'b1;
                rd_d        = rd_q + AW'(1);
                wr_en       = push_ok;
            end else if (push_ok) begin
                out_data_d  = frame;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            wr_en = push_ok;
        end
        wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
        level_d = level_q + LW'(push_ok) - LW'(pop);
        ovf_d   = ovf_q || drop;
        drop_d  = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk320 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= ACC_IDLE;
            req_cnt_q    <= '0;
            tt_cap_q     <= '0;
            ta_max_q     <= '0;
            bc_id_q      <= '0;
            orbit_pend_q <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            level_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            req_cnt_q    <= req_cnt_d;
            tt_cap_q     <= tt_cap_d;
            ta_max_q     <= ta_max_d;
            bc_id_q      <= bc_id_d;
            orbit_pend_q <= orbit_pend_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            level_q      <= level_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
        end
    end

    always_ff @(posedge clk320) begin
        if (wr_en) mem_q[wr_q] <= frame;
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign fifo_level = level_q;
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_trigger_frame_packer.sv
// Randomized and directed bench for trigger_frame_packer against a per-BC
// behavioural model (request list summary + bounded frame queue).
module tb_trigger_frame_packer;

    localparam int TT_W = 7;
    localparam int TA_W = 12;
    localparam int DEPTH = 16;
    localparam int ORBIT_LEN = 3564;
    localparam int FW = 15 + TT_W + TA_W;

    logic            clk320 = 1'b0;
    logic            rst_n;
    logic [2:0]      mt_cou;
    logic            tcm_req;
    logic [TT_W-1:0] tt;
    logic [TA_W-1:0] ta;
    logic            orbit;
    logic [FW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      fifo_level;
    logic            ovf;
    logic [15:0]     drop_cnt;

    trigger_frame_packer #(
        .TT_W(TT_W), .TA_W(TA_W), .DEPTH(DEPTH), .ORBIT_LEN(ORBIT_LEN), .FRAME_W(FW)
    ) dut (
        .clk320(clk320), .rst_n(rst_n), .mt_cou(mt_cou), .tcm_req(tcm_req),
        .tt(tt), .ta(ta), .orbit(orbit), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk320 = ~clk320;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int              m_cnt;
    logic [TT_W-1:0] m_tt;
    logic [TA_W-1:0] m_ta;
    int              m_bc;
    bit              m_pend;
    logic [FW-1:0]   mq[$];
    logic            m_ovf;
    logic [15:0]     m_drop;
    logic            exp_v;
    logic [4:0]      exp_lvl;
    logic [FW-1:0]   exp_d;

    task automatic model_clear();
        m_cnt = 0; m_tt = '0; m_ta = '0; m_bc = 0; m_pend = 0;
        mq.delete(); m_ovf = 1'b0; m_drop = '0;
        exp_v = 1'b0; exp_lvl = '0; exp_d = '0;
    endtask

    task automatic model_edge();
        bit            pop, have;
        logic [FW-1:0] frm;
        have = 0;
        frm  = '0;
        if (rst_n) begin
            pop = (mq.size() != 0) && out_ready;
            if (tcm_req) begin
                if (m_cnt == 0) begin m_tt = tt; m_ta = ta; end
                else if (ta > m_ta) m_ta = ta;
                m_cnt++;
            end
            if (mt_cou == 3'd7) begin
                if (m_cnt > 0) begin
                    frm  = {12'(m_bc), 3'((m_cnt > 7) ? 7 : m_cnt), m_tt, m_ta};
                    have = 1;
                end
                m_cnt = 0;
                if (m_pend || orbit) begin m_bc = 0; m_pend = 0; end
                else m_bc = (m_bc + 1) % ORBIT_LEN;
            end else if (orbit) begin
                m_pend = 1;
            end
            if (pop) void'(mq.pop_front());
            if (have) begin
                if (mq.size() < DEPTH) mq.push_back(frm);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
        end
        exp_v   = (mq.size() != 0);
        exp_lvl = 5'(mq.size());
        exp_d   = exp_v ? mq[0] : '0;
    endtask

    task automatic step();
        @(posedge clk320);
        model_edge();
        #1;
        mt_cou  = mt_cou + 3'd1;
        tcm_req = 1'b0;
        orbit   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tcm_req = 1'b0; orbit = 1'b0; out_ready = 1'b0;
        model_clear();
        #1;
        step();
        step();
        rst_n  = 1'b1;
        mt_cou = 3'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mt_cou = '0; tcm_req = 1'b0; tt = '0; ta = '0;
        orbit = 1'b0; out_ready = 1'b0;
        model_clear();
        #3;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_vec++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        step();
        rst_n = 1'b1;
        mt_cou = 3'd0;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 6 * 8; c++) begin
            if (c == 5 * 8 + 3) begin tcm_req = 1'b1; tt = 7'h25; ta = 12'h100; end
            step();
            n_vec++;
            if (out_valid !== exp_v || fifo_level !== exp_lvl || (exp_v && out_data !== exp_d)) begin
                n_err++;
                $display("FAIL single_model: got v=%b lvl=%0d d=%h want v=%b lvl=%0d d=%h",
                         out_valid, fifo_level, out_data, exp_v, exp_lvl, exp_d);
            end
            if (c == 5 * 8 + 6) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got v=%b want 0", out_valid); end
            end
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== {12'd5, 3'd1, 7'h25, 12'h100}) begin
            n_err++;
            $display("FAIL single_frame: got v=%b d=%h want v=1 d=%h", out_valid, out_data, {12'd5, 3'd1, 7'h25, 12'h100});
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== {12'd5, 3'd1, 7'h25, 12'h100}) begin
                n_err++; $display("FAIL single_hold: got v=%b d=%h", out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin n_err++; $display("FAIL single_pop: got v=%b lvl=%0d want 0 0", out_valid, fifo_level); end
    endtask

    task automatic test_multi();
        logic [TT_W-1:0] tts [3] = '{7'h11, 7'h22, 7'h33};
        logic [TA_W-1:0] tas [3] = '{12'h050, 12'h3FF, 12'h200};
        do_reset();
        for (int p = 0; p < 8; p++) begin
            if (p == 0) begin tcm_req = 1'b1; tt = tts[0]; ta = tas[0]; end
            if (p == 2) begin tcm_req = 1'b1; tt = tts[1]; ta = tas[1]; end
            if (p == 7) begin tcm_req = 1'b1; tt = tts[2]; ta = tas[2]; end
            step();
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== {12'd0, 3'd3, 7'h11, 12'h3FF} || out_data !== exp_d) begin
            n_err++;
            $display("FAIL multi_frame: got v=%b d=%h want v=1 d=%h", out_valid, out_data, {12'd0, 3'd3, 7'h11, 12'h3FF});
        end
        n_vec++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL multi_level: got %0d want 1", fifo_level); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 8; p++) begin
            tcm_req = 1'b1; tt = 7'(p + 1); ta = 12'(p * 3);
            step();
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== {12'd0, 3'd7, 7'd1, 12'd21}) begin
            n_err++; $display("FAIL sat_frame: got v=%b d=%h want d=%h", out_valid, out_data, {12'd0, 3'd7, 7'd1, 12'd21});
        end
        step();
        n_vec++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL sat_level: got %0d want 1", fifo_level); end
    endtask

    task automatic test_orbit();
        do_reset();
        for (int b = 0; b < 102; b++) begin
            for (int p = 0; p < 8; p++) begin
                if (b == 100 && p == 4) orbit = 1'b1;
                if (b == 100 && p == 5) begin tcm_req = 1'b1; tt = 7'h01; ta = 12'h001; end
                if (b == 101 && p == 1) begin tcm_req = 1'b1; tt = 7'h02; ta = 12'h002; end
                step();
                n_vec++;
                if (out_valid !== exp_v || fifo_level !== exp_lvl || (exp_v && out_data !== exp_d)) begin
                    n_err++;
                    $display("FAIL orbit_model: got v=%b lvl=%0d d=%h want v=%b lvl=%0d d=%h",
                             out_valid, fifo_level, out_data, exp_v, exp_lvl, exp_d);
                end
            end
        end
        n_vec++; if (out_data[FW-1 -: 12] !== 12'd100) begin n_err++; $display("FAIL orbit_bc100: got %0d want 100", out_data[FW-1 -: 12]); end
        n_vec++; if (fifo_level !== 5'd2) begin n_err++; $display("FAIL orbit_level: got %0d want 2", fifo_level); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_data[FW-1 -: 12] !== 12'd0) begin n_err++; $display("FAIL orbit_bc0: got %0d want 0", out_data[FW-1 -: 12]); end
    endtask

    task automatic test_wrap();
        logic [11:0] want;
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < ORBIT_LEN + 1; b++) begin
            for (int p = 0; p < 8; p++) begin
                if (b >= ORBIT_LEN - 2 && p == 2) begin tcm_req = 1'b1; tt = 7'(b); ta = 12'(b); end
                step();
                n_vec++;
                if (out_valid !== exp_v || fifo_level !== exp_lvl || (exp_v && out_data !== exp_d)) begin
                    n_err++;
                    $display("FAIL wrap_model: got v=%b lvl=%0d d=%h want v=%b lvl=%0d d=%h",
                             out_valid, fifo_level, out_data, exp_v, exp_lvl, exp_d);
                end
            end
            if (b >= ORBIT_LEN - 2) begin
                want = (b == ORBIT_LEN) ? 12'd0 : 12'(b);
                n_vec++;
                if (out_valid !== 1'b1 || out_data[FW-1 -: 12] !== want) begin
                    n_err++; $display("FAIL wrap_bc: got v=%b bc=%0d want v=1 bc=%0d", out_valid, out_data[FW-1 -: 12], want);
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int b = 0; b < 18; b++) begin
            for (int p = 0; p < 8; p++) begin
                if (p == 0) begin tcm_req = 1'b1; tt = 7'($urandom); ta = 12'($urandom); end
                step();
                n_vec++;
                if (out_valid !== exp_v || fifo_level !== exp_lvl || ovf !== m_ovf || drop_cnt !== m_drop || (exp_v && out_data !== exp_d)) begin
                    n_err++;
                    $display("FAIL ovf_model: got v=%b lvl=%0d d=%h ovf=%b drop=%0d want v=%b lvl=%0d d=%h ovf=%b drop=%0d",
                             out_valid, fifo_level, out_data, ovf, drop_cnt, exp_v, exp_lvl, exp_d, m_ovf, m_drop);
                end
            end
        end
        n_vec++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        n_vec++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data[FW-1 -: 12] !== 12'(k)) begin
                n_err++; $display("FAIL drain_seq: got v=%b bc=%0d want v=1 bc=%0d", out_valid, out_data[FW-1 -: 12], k);
            end
            step();
        end
        n_vec++;
        if (out_valid !== 1'b0 || fifo_level !== 5'd0 || ovf !== 1'b1) begin
            n_err++; $display("FAIL drain_end: got v=%b lvl=%0d ovf=%b want 0 0 1", out_valid, fifo_level, ovf);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tcm_req   = 1'($urandom_range(0, 1));
            tt        = 7'($urandom);
            ta        = 12'($urandom);
            orbit     = ($urandom_range(0, 63) == 0);
            out_ready = (c < 800) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
            step();
            n_vec++;
            if (out_valid !== exp_v || fifo_level !== exp_lvl || ovf !== m_ovf || drop_cnt !== m_drop || (exp_v && out_data !== exp_d)) begin
                n_err++;
                $display("FAIL rand_model: cyc=%0d got v=%b lvl=%0d d=%h ovf=%b drop=%0d want v=%b lvl=%0d d=%h ovf=%b drop=%0d",
                         c, out_valid, fifo_level, out_data, ovf, drop_cnt, exp_v, exp_lvl, exp_d, m_ovf, m_drop);
            end
        end
    endtask

    task automatic test_reset_activity();
        do_reset();
        for (int c = 0; c < 5 * 8 + 4; c++) begin
            if (mt_cou == 3'd0 || c == 5 * 8 + 2) begin tcm_req = 1'b1; tt = 7'($urandom); ta = 12'($urandom); end
            step();
        end
        n_vec++; if (fifo_level !== 5'd5) begin n_err++; $display("FAIL rstact_pre: got lvl=%0d want 5", fifo_level); end
        rst_n = 1'b0;
        model_clear();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || fifo_level !== 5'd0 || out_data !== '0) begin
            n_err++; $display("FAIL rstact_async: got v=%b lvl=%0d d=%h want 0 0 0", out_valid, fifo_level, out_data);
        end
        step();
        step();
        mt_cou = 3'd5;
        rst_n  = 1'b1;
        step();
        tcm_req = 1'b1; tt = 7'h5A; ta = 12'h0AB;
        step();
        step();
        n_vec++;
        if (out_valid !== 1'b1 || fifo_level !== 5'd1 || out_data !== {12'd0, 3'd1, 7'h5A, 12'h0AB}) begin
            n_err++;
            $display("FAIL rstact_frame: got v=%b lvl=%0d d=%h want v=1 lvl=1 d=%h",
                     out_valid, fifo_level, out_data, {12'd0, 3'd1, 7'h5A, 12'h0AB});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_saturation();
        test_orbit();
        test_overflow();
        test_reset_activity();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
